// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg
//   Shared constants and helpers for the instruction fetch queue slice.
//   No ports; imported by inst_fetch_queue and ifq_ram_2w2r.
package inst_fetch_queue_pkg;

  localparam int IFQ_DEPTH   = 16;
  localparam int IFQ_INST_W  = 32;
  localparam int IFQ_PC_W    = 32;
  localparam int FETCH_WIDTH = 2;
  localparam int ISSUE_WIDTH = 2;
  localparam int PC_STEP     = 4;

  // Issue stage may ask for 3; only two words are ever presented.
  function automatic logic [1:0] clamp_issue(input logic [1:0] num);
    return (num > 2'(ISSUE_WIDTH)) ? 2'(ISSUE_WIDTH) : num;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// ifq_ram_2w2r
//   DEPTH x WIDTH register array, two write ports and two asynchronous read ports.
//   Ports:
//     i_clk                       write clock
//     i_we1/i_waddr1/i_wdata1     write port 1
//     i_we2/i_waddr2/i_wdata2     write port 2 (address never equals port 1 when both enabled)
//     i_raddr1/o_rdata1           async read port 1
//     i_raddr2/o_rdata2           async read port 2
//   The array has no reset; the top gates read data with its valid flags.
module ifq_ram_2w2r #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we1,
  input  logic [AW-1:0]    i_waddr1,
  input  logic [WIDTH-1:0] i_wdata1,
  input  logic             i_we2,
  input  logic [AW-1:0]    i_waddr2,
  input  logic [WIDTH-1:0] i_wdata2,
  input  logic [AW-1:0]    i_raddr1,
  output logic [WIDTH-1:0] o_rdata1,
  input  logic [AW-1:0]    i_raddr2,
  output logic [WIDTH-1:0] o_rdata2
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
    if (i_we2) r_mem[i_waddr2] <= i_wdata2;
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Dual-issue instruction queue between the instruction cache and decode.
//   Accepts 0/1/2 fetched words per cycle, delivers 0/1/2 in-order words per cycle,
//   and empties in one cycle on flush.
//   Optional feature macro: INST_FETCH_QUEUE_BYPASS_EN
//     defined   -> when empty and not flushing, push data drives the outputs in the same cycle
//     undefined -> one-cycle push-to-output latency, no path from i_push_* to o_out_*
//   Ports:
//     i_clk, i_rst                synchronous active-high reset
//     i_flush                     drop contents plus same-cycle push/pop
//     i_push_en1/2, i_push_pc,
//     i_push_inst1/2              fetch words; slot 2 PC = i_push_pc + 4
//     i_pop_num                   words consumed this cycle (3 acts as 2)
//     o_out_valid1/2, o_out_inst1/2, o_out_pc1/2   head and head+1 entries
//     o_full                      registered stall to fetch
//     o_empty, o_count            occupancy
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter  int DEPTH  = IFQ_DEPTH,
  parameter  int INST_W = IFQ_INST_W,
  parameter  int PC_W   = IFQ_PC_W,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push_en1,
  input  logic              i_push_en2,
  input  logic [PC_W-1:0]   i_push_pc,
  input  logic [INST_W-1:0] i_push_inst1,
  input  logic [INST_W-1:0] i_push_inst2,
  input  logic [1:0]        i_pop_num,
  output logic              o_out_valid1,
  output logic              o_out_valid2,
  output logic [INST_W-1:0] o_out_inst1,
  output logic [INST_W-1:0] o_out_inst2,
  output logic [PC_W-1:0]   o_out_pc1,
  output logic [PC_W-1:0]   o_out_pc2,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  localparam int          ENT_W    = INST_W + PC_W;
  // Full is raised two entries short of DEPTH: with one slot kept unused, a
  // 2-wide push must still fit when the flag is low.
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH - 2);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             r_full;

  logic [AW:0]      w_count;
  logic             w_empty;
  logic             w_bypass;
  logic             w_push_ok;
  logic [1:0]       w_push_n;
  logic [1:0]       w_pop_req;
  logic [1:0]       w_pop_eff;
  logic [AW:0]      w_push_ext;
  logic [AW:0]      w_pop_ext;
  logic [AW:0]      w_avail;
  logic [AW:0]      w_next_count;
  logic [ENT_W-1:0] w_rdata1;
  logic [ENT_W-1:0] w_rdata2;
  logic             w_valid1;
  logic             w_valid2;

  assign w_count   = r_wptr - r_rptr;
  assign w_empty   = (w_count == '0);
  assign w_pop_req = clamp_issue(i_pop_num);
  assign w_push_ok = i_push_en1 & ~r_full & ~i_flush;
  assign w_push_n  = w_push_ok ? (i_push_en2 ? 2'd2 : 2'd1) : 2'd0;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & ~i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push_ext = {{(AW-1){1'b0}}, w_push_n};

  // In bypass the words being pushed are already poppable. They are still
  // written, and the read pointer steps past the ones consumed this cycle,
  // which leaves the same visible contents as skipping their write.
  assign w_avail = w_bypass ? (w_count + w_push_ext) : w_count;

  always_comb begin
    w_pop_eff = w_pop_req;
    if (w_avail < {{(AW-1){1'b0}}, w_pop_req}) w_pop_eff = w_avail[1:0];
  end

  assign w_pop_ext    = {{(AW-1){1'b0}}, w_pop_eff};
  assign w_next_count = w_count + w_push_ext - w_pop_ext;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else begin
      r_wptr <= r_wptr + w_push_ext;
      r_rptr <= r_rptr + w_pop_ext;
      r_full <= (w_next_count >= FULL_LVL);
    end
  end

  ifq_ram_2w2r #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .i_clk    (i_clk),
    .i_we1    (w_push_ok),
    .i_waddr1 (r_wptr[AW-1:0]),
    .i_wdata1 ({i_push_pc, i_push_inst1}),
    .i_we2    (w_push_ok & i_push_en2),
    .i_waddr2 (r_wptr[AW-1:0] + AW'(1)),
    .i_wdata2 ({i_push_pc + PC_W'(PC_STEP), i_push_inst2}),
    .i_raddr1 (r_rptr[AW-1:0]),
    .o_rdata1 (w_rdata1),
    .i_raddr2 (r_rptr[AW-1:0] + AW'(1)),
    .o_rdata2 (w_rdata2)
  );

  assign w_valid1 = (w_count != '0);
  assign w_valid2 = (w_count >= (AW+1)'(2));

  // Read data is forced to zero when invalid so the reset state reads clean
  // without having to reset the storage array.
  always_comb begin
    o_out_valid1 = w_valid1;
    o_out_valid2 = w_valid2;
    o_out_inst1  = w_valid1 ? w_rdata1[INST_W-1:0]     : '0;
    o_out_pc1    = w_valid1 ? w_rdata1[INST_W +: PC_W] : '0;
    o_out_inst2  = w_valid2 ? w_rdata2[INST_W-1:0]     : '0;
    o_out_pc2    = w_valid2 ? w_rdata2[INST_W +: PC_W] : '0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    if (w_bypass) begin
      o_out_valid1 = i_push_en1;
      o_out_valid2 = i_push_en1 & i_push_en2;
      o_out_inst1  = i_push_en1 ? i_push_inst1 : '0;
      o_out_pc1    = i_push_en1 ? i_push_pc    : '0;
      o_out_inst2  = (i_push_en1 & i_push_en2) ? i_push_inst2 : '0;
      o_out_pc2    = (i_push_en1 & i_push_en2) ? (i_push_pc + PC_W'(PC_STEP)) : '0;
    end
`endif
  end

  assign o_full  = r_full;
  assign o_empty = w_empty;
  assign o_count = w_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        push_en1, push_en2;
  logic [31:0] push_pc, push_inst1, push_inst2;
  logic [1:0]  pop_num;
  logic        out_valid1, out_valid2;
  logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2;
  logic        full, empty;
  logic [4:0]  count;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_push_en1   (push_en1),
    .i_push_en2   (push_en2),
    .i_push_pc    (push_pc),
    .i_push_inst1 (push_inst1),
    .i_push_inst2 (push_inst2),
    .i_pop_num    (pop_num),
    .o_out_valid1 (out_valid1),
    .o_out_valid2 (out_valid2),
    .o_out_inst1  (out_inst1),
    .o_out_inst2  (out_inst2),
    .o_out_pc1    (out_pc1),
    .o_out_pc2    (out_pc2),
    .o_full       (full),
    .o_empty      (empty),
    .o_count      (count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;
  bit   mon_en = 0;
  bit   m_full = 0;
  int   byp_skip = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: whatever the issue side consumes this cycle must be the oldest
  // scoreboard entries, and the valid flags must match the model occupancy.
  always @(negedge clk) begin
    int   n, take, np;
    bit   live;
    ent_t e;
    byp_skip = 0;
    if (mon_en && !rst && !flush) begin
      n    = (pop_num == 2'd0) ? 0 : (pop_num == 2'd1) ? 1 : 2;
      live = 0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      live = (sb.size() == 0) && push_en1;
`endif
      if (live) begin
        np       = push_en2 ? 2 : 1;
        byp_skip = (n < np) ? n : np;
      end else begin
        chk("valid1", 64'(out_valid1), 64'(sb.size() >= 1));
        chk("valid2", 64'(out_valid2), 64'(sb.size() >= 2));
        take = (n < sb.size()) ? n : sb.size();
        for (int k = 0; k < take; k++) begin
          e = sb.pop_front();
          if (k == 0) begin
            chk("head_inst1", 64'(out_inst1), 64'(e.inst));
            chk("head_pc1",   64'(out_pc1),   64'(e.pc));
          end else begin
            chk("head_inst2", 64'(out_inst2), 64'(e.inst));
            chk("head_pc2",   64'(out_pc2),   64'(e.pc));
          end
        end
      end
    end
  end

  task automatic step(input logic e1, input logic e2, input logic [31:0] pc,
                      input logic [31:0] i1, input logic [31:0] i2,
                      input logic [1:0] pn, input logic fl);
    ent_t e;
    int   np;
    push_en1 = e1; push_en2 = e2; push_pc = pc;
    push_inst1 = i1; push_inst2 = i2; pop_num = pn; flush = fl;
    @(posedge clk);
    if (rst || fl) begin
      sb.delete();
      m_full = 0;
    end else begin
      if (e1 && !m_full) begin
        np = e2 ? 2 : 1;
        for (int k = byp_skip; k < np; k++) begin
          e.pc   = pc + 32'(4 * k);
          e.inst = (k == 0) ? i1 : i2;
          sb.push_back(e);
        end
      end
      m_full = (sb.size() >= DEPTH - 2);
    end
    #1;
  endtask

  task automatic drain();
    for (int it = 0; it < 12; it++) begin
      if (empty) break;
      step(0, 0, 0, 0, 0, 2'd2, 0);
    end
    chk("drain_empty", 64'(empty), 64'd1);
  endtask

  initial begin
    logic [31:0] pc_f;
    rst = 1; flush = 0; push_en1 = 0; push_en2 = 0;
    push_pc = 0; push_inst1 = 0; push_inst2 = 0; pop_num = 0;

    // reset
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    chk("rst_empty",  64'(empty),      64'd1);
    chk("rst_count",  64'(count),      64'd0);
    chk("rst_valid1", 64'(out_valid1), 64'd0);
    chk("rst_valid2", 64'(out_valid2), 64'd0);
    chk("rst_full",   64'(full),       64'd0);
    mon_en = 1;

    // dual push
    step(1, 1, 32'hBFC0_0000, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0);
    chk("dual_count", 64'(count),     64'd2);
    chk("dual_pc1",   64'(out_pc1),   64'hBFC0_0000);
    chk("dual_pc2",   64'(out_pc2),   64'hBFC0_0004);
    chk("dual_inst1", 64'(out_inst1), 64'hAAAA_0001);
    chk("dual_inst2", 64'(out_inst2), 64'hBBBB_0002);

    // fill
    pc_f = 32'hBFC0_0008;
    for (int it = 0; it < 10; it++) begin
      if (full) break;
      step(1, 1, pc_f, {16'hF000, pc_f[15:0]}, {16'hF001, pc_f[15:0]}, 0, 0);
      pc_f = pc_f + 32'd8;
    end
    chk("fill_full",  64'(full),  64'd1);
    chk("fill_count", 64'(count), 64'd14);
    step(1, 1, 32'h0000_DEAD, 32'hDEAD_0001, 32'hDEAD_0002, 0, 0);
    chk("drop_count", 64'(count),     64'd14);
    chk("drop_full",  64'(full),      64'd1);
    chk("drop_inst1", 64'(out_inst1), 64'hAAAA_0001);
    chk("drop_pc1",   64'(out_pc1),   64'hBFC0_0000);
    drain();

    // park pointers at 15, then push 2 / pop 1 across the wrap
    step(1, 0, 32'h0000_0100, 32'h5555_0001, 0, 0, 0);
    step(0, 0, 0, 0, 0, 2'd1, 0);
    chk("park_count", 64'(count), 64'd0);
    pc_f = 32'h0000_1000;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, pc_f, {16'hC000, pc_f[15:0]}, {16'hC001, pc_f[15:0]}, 2'd1, 0);
      chk("wrap_count", 64'(count), 64'(sb.size()));
      chk("wrap_full",  64'(full),  64'(m_full));
      pc_f = pc_f + 32'd8;
    end
    drain();

    // over-pop
    step(1, 0, 32'h0000_0200, 32'h7777_0001, 0, 0, 0);
    chk("op_count1", 64'(count), 64'd1);
    step(0, 0, 0, 0, 0, 2'd2, 0);
    chk("op_count0", 64'(count),      64'd0);
    chk("op_empty",  64'(empty),      64'd1);
    chk("op_valid1", 64'(out_valid1), 64'd0);
    step(1, 1, 32'h0000_0300, 32'h7777_0002, 32'h7777_0003, 0, 0);
    step(0, 0, 0, 0, 0, 2'd3, 0);
    chk("pop3_count", 64'(count), 64'd0);

    // flush with same-cycle push
    for (int i = 0; i < 4; i++)
      step(1, 1, 32'h0000_0400 + 32'(8 * i), 32'h4444_0000 + 32'(i), 32'h4444_1000 + 32'(i), 0, 0);
    chk("fl_count8", 64'(count), 64'd8);
    step(1, 1, 32'h0000_0500, 32'h5050_0001, 32'h5050_0002, 2'd2, 1);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_empty", 64'(empty), 64'd1);
    chk("fl_full",  64'(full),  64'd0);
    step(1, 1, 32'h0000_0600, 32'h9999_0001, 32'h9999_0002, 0, 0);
    chk("postfl_pc1",   64'(out_pc1),   64'h0000_0600);
    chk("postfl_inst2", 64'(out_inst2), 64'h9999_0002);

    // reset in the middle of traffic
    rst = 1;
    step(1, 1, 32'h0000_0700, 32'h1234_0001, 32'h1234_0002, 2'd1, 0);
    rst = 0;
    chk("mrst_count",  64'(count),      64'd0);
    chk("mrst_empty",  64'(empty),      64'd1);
    chk("mrst_valid1", 64'(out_valid1), 64'd0);

`ifdef INST_FETCH_QUEUE_BYPASS_EN
    push_en1 = 1; push_en2 = 1; push_pc = 32'h8000_0000;
    push_inst1 = 32'hCAFE_0001; push_inst2 = 32'hCAFE_0002; pop_num = 2'd1; flush = 0;
    #2;
    chk("byp_valid1", 64'(out_valid1), 64'd1);
    chk("byp_inst1",  64'(out_inst1),  64'hCAFE_0001);
    step(1, 1, 32'h8000_0000, 32'hCAFE_0001, 32'hCAFE_0002, 2'd1, 0);
    chk("byp_count", 64'(count),     64'd1);
    chk("byp_next",  64'(out_inst1), 64'hCAFE_0002);
    chk("byp_pc",    64'(out_pc1),   64'h8000_0004);
    drain();
`endif

    step(0, 0, 0, 0, 0, 0, 0);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
